// File: rtl/pc_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, runs the imem req/ack
// handshake and hands fetched words to decode.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic        instrValid,
    output logic [31:0] instrOut,
    output logic [31:0] pcOut,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [15:0] branchOffset,
    input  logic        jump,
    input  logic        jumpReg,
    input  logic [31:0] regTarget,
    output logic        fetchError
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ISSUE,
        ERROR
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] instr;
    logic        instr_load;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_next;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] redirect_pc;
    logic        jr_misaligned;

    always_comb begin
        pc_plus4      = pc + 32'd4;
        branch_target = pc_plus4
                      + {{14{branchOffset[15]}}, branchOffset, 2'b00};
        jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
        jr_misaligned = jumpReg && (regTarget[1:0] != 2'b00);
        if (jumpReg) begin
            redirect_pc = regTarget;
        end else if (jump) begin
            redirect_pc = jump_target;
        end else if (branchTaken) begin
            redirect_pc = branch_target;
        end else begin
            redirect_pc = pc_plus4;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        wait_next  = wait_cnt;
        instr_load = 1'b0;
        case (state)
            IDLE: begin
                state_next = REQ;
                wait_next  = 8'd0;
            end
            REQ: begin
                if (imemAck) begin
                    instr_load = 1'b1;
                    state_next = ISSUE;
                end else if (wait_cnt == WAIT_LAST) begin
                    // The Nth silent REQ cycle is the last one allowed.
                    state_next = ERROR;
                end else begin
                    wait_next = wait_cnt + 8'd1;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    if (jr_misaligned) begin
                        state_next = ERROR;
                    end else begin
                        pc_next    = redirect_pc;
                        wait_next  = 8'd0;
                        state_next = REQ;
                    end
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            instr    <= 32'd0;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            wait_cnt <= wait_next;
            if (instr_load) begin
                instr <= imemData;
            end
        end
    end

    assign imemReq    = (state == REQ);
    assign instrValid = (state == ISSUE);
    assign fetchError = (state == ERROR);
    assign imemAddr   = pc;
    assign pcOut      = pc;
    assign instrOut   = instr;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed table, corner sequences
// and random traffic against a transaction-level reference model.
module tb_pc_fetch_sequencer;

    localparam int MAX_WAIT = 15;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam int M_IDLE  = 0;
    localparam int M_REQ   = 1;
    localparam int M_ISSUE = 2;
    localparam int M_ERR   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        instrValid;
    logic [31:0] instrOut;
    logic [31:0] pcOut;
    logic        stall;
    logic        branchTaken;
    logic [15:0] branchOffset;
    logic        jump;
    logic        jumpReg;
    logic [31:0] regTarget;
    logic        fetchError;

    int vectors = 0;
    int miscompares = 0;

    int          m_st;
    int          m_waits;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        br;
        logic [15:0] off;
        logic        jmp;
        logic        jr;
        logic [31:0] rt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    pc_fetch_sequencer #(
        .RESET_PC(RESET_PC),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imemReq(imemReq),
        .imemAddr(imemAddr),
        .imemAck(imemAck),
        .imemData(imemData),
        .instrValid(instrValid),
        .instrOut(instrOut),
        .pcOut(pcOut),
        .stall(stall),
        .branchTaken(branchTaken),
        .branchOffset(branchOffset),
        .jump(jump),
        .jumpReg(jumpReg),
        .regTarget(regTarget),
        .fetchError(fetchError)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] next_pc(
        input logic [31:0] pc,
        input logic [31:0] ins,
        input logic        br,
        input logic [15:0] off,
        input logic        jmp,
        input logic        jr,
        input logic [31:0] rt
    );
        logic [31:0] p4;
        int          words;
        p4 = pc + 32'd4;
        words = int'($signed(off));
        if (jr) return rt;
        if (jmp)
            return (p4 & 32'hF000_0000)
                 | ((ins & 32'h03FF_FFFF) << 2);
        if (br) return p4 + 32'(words * 4);
        return p4;
    endfunction

    task automatic model_reset();
        m_st    = M_IDLE;
        m_waits = 0;
        m_pc    = RESET_PC;
        m_instr = 32'd0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
            return;
        end
        case (m_st)
            M_IDLE: begin
                m_st    = M_REQ;
                m_waits = 0;
            end
            M_REQ: begin
                if (imemAck) begin
                    m_instr = imemData;
                    m_st    = M_ISSUE;
                end else begin
                    m_waits++;
                    if (m_waits >= MAX_WAIT) m_st = M_ERR;
                end
            end
            M_ISSUE: begin
                if (!stall) begin
                    if (jumpReg && (regTarget % 4 != 0)) begin
                        m_st = M_ERR;
                    end else begin
                        m_pc = next_pc(m_pc, m_instr,
                                       branchTaken, branchOffset,
                                       jump, jumpReg, regTarget);
                        m_st    = M_REQ;
                        m_waits = 0;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_all();
        chk("imemReq", 32'(imemReq), 32'(m_st == M_REQ));
        chk("instrValid", 32'(instrValid),
            32'(m_st == M_ISSUE));
        chk("fetchError", 32'(fetchError), 32'(m_st == M_ERR));
        chk("imemAddr", imemAddr, m_pc);
        chk("pcOut", pcOut, m_pc);
        chk("instrOut", instrOut, m_instr);
    endtask

    task automatic quiet();
        stall        = 1'b0;
        branchTaken  = 1'b0;
        branchOffset = 16'd0;
        jump         = 1'b0;
        jumpReg      = 1'b0;
        regTarget    = 32'd0;
        imemAck      = 1'b0;
        imemData     = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        quiet();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        reset = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] data);
        imemAck  = 1'b1;
        imemData = data;
        step();
        imemAck  = 1'b0;
        imemData = 32'd0;
    endtask

    task automatic goto_pc(input logic [31:0] target,
                           input logic [31:0] data);
        jumpReg   = 1'b1;
        regTarget = target;
        step();
        quiet();
        chk("goto_addr", imemAddr, target);
        fetch(data);
        chk("goto_pcOut", pcOut, target);
    endtask

    initial begin
        vecs[0] = '{32'h1000_0010, 32'h0800_0003, 1'b0, 16'h0000,
                    1'b1, 1'b0, 32'h0, 32'h1000_000C};
        vecs[1] = '{32'h0000_0100, 32'h0, 1'b1, 16'hFFFF,
                    1'b0, 1'b0, 32'h0, 32'h0000_0100};
        vecs[2] = '{32'h0000_0100, 32'h0800_0003, 1'b1, 16'hFFFF,
                    1'b1, 1'b1, 32'h400, 32'h0000_0400};
        vecs[3] = '{32'hFFFF_FFFC, 32'h0, 1'b0, 16'h0000,
                    1'b0, 1'b0, 32'h0, 32'h0000_0000};
        vecs[4] = '{32'h0000_0200, 32'h0, 1'b1, 16'h0010,
                    1'b0, 1'b0, 32'h0, 32'h0000_0244};
        vecs[5] = '{32'h0000_0200, 32'h0BFF_FFFF, 1'b0, 16'h0,
                    1'b1, 1'b0, 32'h0, 32'h0FFF_FFFC};
        vecs[6] = '{32'h0000_0000, 32'h0, 1'b1, 16'h8000,
                    1'b0, 1'b0, 32'h0, 32'hFFFE_0004};
        vecs[7] = '{32'hFFFF_FFFC, 32'h0000_0001, 1'b0, 16'h0,
                    1'b1, 1'b0, 32'h0, 32'h0000_0004};
        vecs[8] = '{32'h2000_0000, 32'hFFFF_FFFF, 1'b1, 16'h0040,
                    1'b1, 1'b0, 32'h0, 32'h2FFF_FFFC};

        quiet();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_req", 32'(imemReq), 32'd0);
        chk("rst_addr", imemAddr, RESET_PC);
        reset = 1'b0;

        // Sequential fetch with immediate ack
        step();
        for (int i = 0; i < 3; i++) begin
            chk("seq_req", 32'(imemReq), 32'd1);
            chk("seq_addr", imemAddr, 32'(i * 4));
            fetch(32'h0);
            chk("seq_valid", 32'(instrValid), 32'd1);
            chk("seq_pcOut", pcOut, 32'(i * 4));
            if (i < 2) step();
        end

        // Stall with redirects asserted must hold everything
        step();
        fetch(32'h1234_5678);
        stall       = 1'b1;
        jumpReg     = 1'b1;
        regTarget   = 32'h400;
        branchTaken = 1'b1;
        jump        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(instrValid), 32'd1);
            chk("stall_instr", instrOut, 32'h1234_5678);
            chk("stall_pc", pcOut, 32'hC);
        end
        quiet();
        step();
        chk("post_stall_addr", imemAddr, 32'h10);

        // Ack delayed by four cycles
        chk("wait_req0", 32'(imemReq), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wait_req", 32'(imemReq), 32'd1);
        end
        fetch(32'hABCD_0001);
        chk("wait_valid", 32'(instrValid), 32'd1);

        // Redirect table
        foreach (vecs[i]) begin
            goto_pc(vecs[i].pc, vecs[i].instr);
            branchTaken  = vecs[i].br;
            branchOffset = vecs[i].off;
            jump         = vecs[i].jmp;
            jumpReg      = vecs[i].jr;
            regTarget    = vecs[i].rt;
            step();
            quiet();
            chk($sformatf("vec%0d_next", i), imemAddr, vecs[i].exp);
            fetch(32'h0);
        end

        // Misaligned JR
        jumpReg   = 1'b1;
        regTarget = 32'h402;
        step();
        quiet();
        chk("jr_err", 32'(fetchError), 32'd1);
        chk("jr_req", 32'(imemReq), 32'd0);
        repeat (3) step();
        chk("jr_sticky", 32'(fetchError), 32'd1);

        // Ack on the last allowed REQ cycle
        apply_reset();
        step();
        repeat (MAX_WAIT - 1) step();
        chk("last_req", 32'(imemReq), 32'd1);
        fetch(32'h5555_AAAA);
        chk("last_ack_valid", 32'(instrValid), 32'd1);

        // Timeout with no ack
        apply_reset();
        step();
        repeat (MAX_WAIT - 1) begin
            step();
            chk("to_req", 32'(imemReq), 32'd1);
        end
        step();
        chk("to_err", 32'(fetchError), 32'd1);
        chk("to_req_low", 32'(imemReq), 32'd0);

        // Asynchronous reset in the middle of a REQ cycle
        apply_reset();
        step();
        fetch(32'h0);
        step();
        chk("mid_req_addr", imemAddr, 32'h4);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_req", 32'(imemReq), 32'd0);
        chk("mid_rst_addr", imemAddr, RESET_PC);
        chk("mid_rst_pcOut", pcOut, RESET_PC);
        chk("mid_rst_instr", instrOut, 32'd0);
        chk("mid_rst_err", 32'(fetchError), 32'd0);
        step();
        reset = 1'b0;

        // Random traffic
        begin
            bit drought = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                if (n % 100 == 0) drought = ($urandom % 3 == 0);
                if ((m_st == M_ERR && $urandom % 4 == 0)
                    || $urandom % 400 == 0) begin
                    apply_reset();
                    continue;
                end
                imemAck = drought ? ($urandom % 20 == 0)
                                  : ($urandom % 3 != 0);
                imemData     = $urandom;
                stall        = ($urandom % 4 == 0);
                branchTaken  = ($urandom % 3 == 0);
                branchOffset = 16'($urandom);
                jump         = ($urandom % 5 == 0);
                jumpReg      = ($urandom % 8 == 0);
                regTarget    = $urandom;
                if ($urandom % 16 != 0) regTarget[1:0] = 2'b00;
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Sequences instruction fetch for the MIPS core. Owns the program counter, issues fetch requests to instruction memory over a req/ack handshake, and presents each fetched instruction to decode. Selects the next PC from PC+4, the branch target, the jump target (the 26-bit index shifted left by 2 and joined with PC+4[31:28]) or a register target. A small FSM handles memory wait states, decode stalls, fetch timeout and misaligned-target errors.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 15, maximum REQ cycles allowed without ack before timeout (range 1–255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imemReq  out  1  fetch request to instruction memory.
- imemAddr  out  32  fetch address; always equals the PC register.
- imemAck  in  1  memory returns data this cycle.
- imemData  in  32  instruction word, valid when imemAck=1.
- instrValid  out  1  instrOut/pcOut are valid for decode.
- instrOut  out  32  latched instruction.
- pcOut  out  32  PC of instrOut.
- stall  in  1  decode cannot accept; hold current instruction.
- branchTaken  in  1  take the branch; sampled only when instrValid=1.
- branchOffset  in  16  signed word offset.
- jump  in  1  J/JAL; uses instrOut[25:0].
- jumpReg  in  1  JR; target is regTarget.
- regTarget  in  32  register jump target.
- fetchError  out  1  sticky error flag; cleared only by reset.

## Operation
- States: IDLE, REQ, ISSUE, ERROR. Reset enters IDLE.
- IDLE: all outputs quiet. Moves to REQ on the next clock.
- REQ: imemReq=1. On entry the wait counter clears.
  - If imemAck=1, latch imemData into the instruction register and go to ISSUE.
  - Otherwise increment the counter. After MAX_WAIT consecutive REQ cycles with no ack, go to ERROR.
  - Ack in the first REQ cycle is legal.
- ISSUE: instrValid=1.
  - If stall=1, hold state, PC and instrOut. Redirect inputs are ignored.
  - If stall=0, load the PC with nextPc and go to REQ.
- nextPc priority, computed from pcPlus4 = PC+4:
  1. jumpReg: regTarget.
  2. jump: {pcPlus4[31:28], instrOut[25:0], 2'b00}.
  3. branchTaken: pcPlus4 + (sign-extended branchOffset << 2).
  4. Otherwise: pcPlus4.
- Arithmetic is modulo 2^32. PC 32'hFFFF_FFFC + 4 wraps to 0. Negative branch offsets wrap the same way.
- Misaligned JR: if jumpReg=1, stall=0 and regTarget[1:0]≠0 in ISSUE, go to ERROR and leave the PC unchanged.
- ERROR: fetchError=1, imemReq=0, instrValid=0. Held until reset.
- imemAck outside REQ is ignored.
- Redirect inputs outside ISSUE are ignored.

## Timing
- Reset values: imemReq=0, imemAddr=RESET_PC, instrValid=0, instrOut=0, pcOut=RESET_PC, fetchError=0, wait counter=0.
- All outputs are registered or decoded from state only (Moore). There is no combinational path from inputs to outputs.
- First request: imemReq rises in the 2nd cycle after reset deassertion (IDLE lasts one cycle).
- Minimum throughput: 2 cycles per instruction (REQ with immediate ack, then ISSUE). Each memory wait cycle adds one.
- pcOut equals imemAddr during ISSUE. The new imemAddr appears in the REQ cycle after ISSUE.
- Reset asserted mid-REQ or mid-ISSUE returns all outputs to reset values immediately (asynchronously). Any pending fetch is dropped.
- Timeout: with MAX_WAIT=N, ack on the Nth REQ cycle is accepted. No ack by the Nth cycle gives ERROR in cycle N+1.

## Test plan
- **Reset and sequential fetch.** Reset, then ack every REQ cycle with data 0x0000_0000 and stall=0. Required: imemAddr sequence 0x0, 0x4, 0x8, and instrValid pulses every 2nd cycle with pcOut matching.
- **Jump target.** At PC=0x1000_0010, instrOut=0x0800_0003, jump=1. Required: next imemAddr = 0x1000_000C.
- **Branch.** At PC=0x100, branchTaken=1, offset=16'hFFFF. Required: next address 0x100.
- **Priority.** Same PC, branchTaken, jump and jumpReg all asserted, regTarget=0x400. Required: next address 0x400.
- **Stall and wait states.**
  - Stall for 3 cycles in ISSUE: instrValid held, instrOut and pcOut unchanged, redirect ignored.
  - Delay ack by 4 cycles: imemReq held for 5 cycles.
- **Errors and wrap.**
  - With MAX_WAIT=15 and no ack: fetchError=1 on REQ cycle 16, and imemReq=0 after.
  - JR to 0x402: ERROR.
  - PC=0xFFFF_FFFC: next address 0x0.
  - Reset mid-REQ: outputs return to reset values.
